// File: rtl/root_layer_ctrl_pkg.sv
// Shared router/PE header: root FSM state encodings and the control-packet
// convention used on the router address MSB.
package root_layer_ctrl_pkg;

   // Root controller states; the encoding is also visible on the debug port.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      BCAST = 3'd2,
      COMP  = 3'd3,
      NEXT  = 3'd4
   } root_state_t;

   // Value of the router address MSB that marks a broadcast-done packet.
   localparam logic RX_CTRL_DONE = 1'b1;

   // True when the address MSB carried with a packet marks it as a done packet.
   function automatic logic is_done_pkt(input logic ctrl);
      return ctrl == RX_CTRL_DONE;
   endfunction

endpackage

// File: rtl/root_layer_ctrl_if.sv
// Router-to-root packet channel.
// Handshake: a packet transfers in every cycle where rx_valid && rx_rdy are both
// high at the rising clk edge. rx_rdy depends only on the root's state, never on
// rx_valid, so the router may hold or change its packet freely while rx_rdy is low.
interface root_layer_ctrl_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  rx_valid;
   logic                  rx_ctrl;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_rdy;

   modport master (output rx_valid, output rx_ctrl, output rx_data, input rx_rdy);
   modport slave  (input rx_valid, input rx_ctrl, input rx_data, output rx_rdy);
endinterface

// File: rtl/root_layer_ctrl_tracker.sv
// Bitmap of PEs whose broadcast-done packet has arrived in the current layer.
// Reports completion including the bit being set this cycle, and flags a set
// request that hits an already-set bit.
module done_mask_tracker #(
   parameter int NUM_PE       = 16,
   parameter int PE_IDX_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    set_en,
   input  logic [PE_IDX_WIDTH-1:0] set_idx,
   output logic [NUM_PE-1:0]       mask,
   output logic                    all_set_next,
   output logic                    dup_hit
);

   logic [NUM_PE-1:0] set_vec;

   // One-hot of the bit requested this cycle; out-of-range indices set nothing.
   always_comb begin
      set_vec = '0;
      dup_hit = 1'b0;
      if (set_en && (int'(set_idx) < NUM_PE)) begin
         set_vec[set_idx] = 1'b1;
         dup_hit          = mask[set_idx];
      end
   end

   assign all_set_next = &(mask | set_vec);

   // Mask register: clear has priority over a set in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      mask <= '0;
      else if (clr) mask <= '0;
      else          mask <= mask | set_vec;
   end

endmodule

// File: rtl/root_layer_ctrl.sv
// Root layer controller: sequences a multi-layer network run. Each layer it
// pulses pe_start_calc, waits for a broadcast-done packet from every PE, then
// waits for every PE to report compute done before moving to the next layer.
module root_layer_ctrl
   import root_layer_ctrl_pkg::*;
#(
   parameter int NUM_PE       = 16,
   parameter int PE_IDX_WIDTH = 4,
   parameter int LAYER_WIDTH  = 4,
   parameter int DATA_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [LAYER_WIDTH-1:0] layer_no,
   root_layer_ctrl_if.slave       rx,
   input  logic [NUM_PE-1:0]      pe_comp_done,
   output logic                   pe_start_calc,
   output logic [LAYER_WIDTH-1:0] layer_idx,
   output logic                   busy,
   output logic                   run_done,
   output logic                   dup_err,
   output root_state_t            state_dbg
);

   // Payload values at or above NUM_PE name no PE on this network.
   localparam logic [DATA_WIDTH-1:0] NUM_PE_D = DATA_WIDTH'(NUM_PE);

   root_state_t            state, state_nxt;
   logic [LAYER_WIDTH-1:0] layer_no_q;
   logic                   done_all_q;
   logic                   accept, idx_ok, set_en, start_ok, last_layer;
   logic                   all_set_next, dup_hit;
   logic [NUM_PE-1:0]      bcast_mask;

   assign accept     = rx.rx_valid & rx.rx_rdy;
   assign idx_ok     = rx.rx_data < NUM_PE_D;
   assign set_en     = accept & is_done_pkt(rx.rx_ctrl) & idx_ok;
   assign start_ok   = start & (state == IDLE);
   assign last_layer = (layer_idx == layer_no_q);

   done_mask_tracker #(
      .NUM_PE       (NUM_PE),
      .PE_IDX_WIDTH (PE_IDX_WIDTH)
   ) u_tracker (
      .clk          (clk),
      .rst          (rst),
      .clr          (state == START),
      .set_en       (set_en),
      .set_idx      (rx.rx_data[PE_IDX_WIDTH-1:0]),
      .mask         (bcast_mask),
      .all_set_next (all_set_next),
      .dup_hit      (dup_hit)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)        state_nxt = START;
         START:                     state_nxt = BCAST;
         BCAST:   if (all_set_next) state_nxt = COMP;
         COMP:    if (done_all_q)   state_nxt = NEXT;
         NEXT:    state_nxt = last_layer ? IDLE : START;
         default:                   state_nxt = IDLE;
      endcase
   end

   // Run bookkeeping: captured layer count, layer index, sticky duplicate flag,
   // and the registered all-PEs-computed check (only armed while in COMP).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         layer_no_q <= '0;
         layer_idx  <= '0;
         dup_err    <= 1'b0;
         done_all_q <= 1'b0;
      end else begin
         done_all_q <= (state == COMP) && (&pe_comp_done);
         if (start_ok) begin
            layer_no_q <= layer_no;
            layer_idx  <= '0;
            dup_err    <= 1'b0;
         end else begin
            if (dup_hit) dup_err <= 1'b1;
            if ((state == NEXT) && !last_layer) layer_idx <= layer_idx + 1'b1;
         end
      end
   end

   // Moore decode of the state register; all zero while rst holds IDLE.
   assign rx.rx_rdy     = (state == BCAST) || (state == COMP);
   assign pe_start_calc = (state == START);
   assign busy          = (state != IDLE);
   assign run_done      = (state == NEXT) && last_layer;
   assign state_dbg     = state;

endmodule

// File: tb/tb_root_layer_ctrl.sv
// Bench for root_layer_ctrl: reset checks, single and multi-layer runs,
// a vector table for duplicate/ignored packets, start-while-busy, mid-run
// reset and a maximum-length run.
module tb_root_layer_ctrl;
   import root_layer_ctrl_pkg::*;

   localparam int NUM_PE = 16;
   localparam int LW     = 4;
   localparam int DW     = 16;

   logic              clk;
   logic              rst;
   logic              start;
   logic [LW-1:0]     layer_no;
   logic [NUM_PE-1:0] pe_comp_done;
   logic              pe_start_calc;
   logic [LW-1:0]     layer_idx;
   logic              busy, run_done, dup_err;
   root_state_t       state_dbg;

   root_layer_ctrl_if #(.DATA_WIDTH(DW)) rx_if ();

   root_layer_ctrl #(
      .NUM_PE(NUM_PE), .PE_IDX_WIDTH(4), .LAYER_WIDTH(LW), .DATA_WIDTH(DW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .layer_no(layer_no), .rx(rx_if),
      .pe_comp_done(pe_comp_done), .pe_start_calc(pe_start_calc),
      .layer_idx(layer_idx), .busy(busy), .run_done(run_done),
      .dup_err(dup_err), .state_dbg(state_dbg)
   );

   // Clock and reset-time defaults.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int run_done_cnt = 0;
   int exp_runs = 0;
   logic [LW-1:0] exp_q[$];

   typedef struct {
      logic          vld;
      logic          ctrl;
      logic [DW-1:0] data;
      root_state_t   exp_state;
      logic          exp_dup;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Scoreboard: every pe_start_calc pulse must match the next expected layer.
   always @(negedge clk) begin
      if (!rst) begin
         if (pe_start_calc) begin
            if (exp_q.size() == 0) check("start_unexpected", pe_start_calc, 0);
            else begin
               logic [LW-1:0] e;
               e = exp_q.pop_front();
               check("start_layer_idx", layer_idx, e);
            end
         end
         if (run_done) run_done_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic ctrl, input logic [DW-1:0] data);
      rx_if.rx_valid = 1'b1;
      rx_if.rx_ctrl  = ctrl;
      rx_if.rx_data  = data;
      tick();
      rx_if.rx_valid = 1'b0;
   endtask

   task automatic wait_state(input root_state_t s, input int budget, input string name);
      int n = 0;
      while (state_dbg != s && n < budget) begin
         tick();
         n++;
      end
      check(name, state_dbg, s);
   endtask

   task automatic do_start(input logic [LW-1:0] ln);
      start    = 1'b1;
      layer_no = ln;
      tick();
      start    = 1'b0;
      check("start_latency", pe_start_calc, 1);
      check("busy_after_start", busy, 1);
      check("rdy_in_start", rx_if.rx_rdy, 0);
   endtask

   // Deliver all done packets in random order and check COMP entry latency.
   task automatic bcast_all();
      int perm[NUM_PE];
      for (int i = 0; i < NUM_PE; i++) perm[i] = i;
      for (int i = NUM_PE - 1; i > 0; i--) begin
         int j, t;
         j = $urandom_range(i, 0);
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      wait_state(BCAST, 4, "reach_bcast");
      check("rdy_in_bcast", rx_if.rx_rdy, 1);
      for (int i = 0; i < NUM_PE; i++) begin
         send(1'b1, DW'(perm[i]));
         if (i == NUM_PE - 2) check("bcast_hold", state_dbg, BCAST);
      end
      check("comp_entry", state_dbg, COMP);
   endtask

   // From COMP: compute-done seen, registered, then NEXT.
   task automatic finish_comp();
      pe_comp_done = '1;
      tick();
      check("comp_registered", state_dbg, COMP);
      tick();
      check("reach_next", state_dbg, NEXT);
      pe_comp_done = '0;
   endtask

   task automatic run_layers(input int n);
      for (int l = 0; l < n; l++) begin
         bcast_all();
         finish_comp();
      end
      exp_runs++;
      wait_state(IDLE, 3, "run_idle");
      check("run_done_count", run_done_cnt, exp_runs);
      check("busy_after_run", busy, 0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      layer_no = '0;
      pe_comp_done = '0;
      rx_if.rx_valid = 1'b0;
      rx_if.rx_ctrl = 1'b0;
      rx_if.rx_data = '0;

      // Reset state.
      tick(); tick();
      check("rst_state", state_dbg, IDLE);
      check("rst_busy", busy, 0);
      check("rst_rdy", rx_if.rx_rdy, 0);
      check("rst_start_calc", pe_start_calc, 0);
      check("rst_run_done", run_done, 0);
      check("rst_layer_idx", layer_idx, 0);
      check("rst_dup", dup_err, 0);
      rst = 1'b0;
      tick();

      // Single layer run.
      exp_q.push_back(4'd0);
      do_start(4'd0);
      run_layers(1);

      // Three layers.
      for (int l = 0; l < 3; l++) exp_q.push_back(LW'(l));
      do_start(4'd2);
      run_layers(3);

      // Duplicate and ignored packets from a vector table.
      vecs.push_back('{1'b1, 1'b1, 16'd5,  BCAST, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 16'd3,  BCAST, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 16'd20, BCAST, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 16'd3,  BCAST, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 16'd4,  BCAST, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 16'd7,  BCAST, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 16'd5,  BCAST, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 16'd9,  BCAST, 1'b1});
      for (int p = 0; p < NUM_PE; p++)
         if (p != 3 && p != 4 && p != 5)
            vecs.push_back('{1'b1, 1'b1, DW'(p), (p == NUM_PE - 1) ? COMP : BCAST, 1'b1});
      exp_q.push_back(4'd0);
      do_start(4'd0);
      wait_state(BCAST, 4, "tbl_bcast");
      for (int i = 0; i < vecs.size(); i++) begin
         rx_if.rx_valid = vecs[i].vld;
         rx_if.rx_ctrl  = vecs[i].ctrl;
         rx_if.rx_data  = vecs[i].data;
         tick();
         rx_if.rx_valid = 1'b0;
         check($sformatf("tbl_state_%0d", i), state_dbg, vecs[i].exp_state);
         check($sformatf("tbl_dup_%0d", i), dup_err, vecs[i].exp_dup);
      end
      finish_comp();
      exp_runs++;
      wait_state(IDLE, 3, "tbl_idle");
      check("dup_sticky_idle", dup_err, 1);
      check("tbl_run_done_count", run_done_cnt, exp_runs);

      // Start while busy is ignored; dup_err clears on the accepted start.
      exp_q.push_back(4'd0);
      do_start(4'd0);
      check("dup_cleared", dup_err, 0);
      start = 1'b1;
      layer_no = 4'd3;
      tick();
      start = 1'b0;
      run_layers(1);

      // Reset during COMP of layer 1.
      exp_q.push_back(4'd0);
      exp_q.push_back(4'd1);
      do_start(4'd2);
      bcast_all();
      finish_comp();
      bcast_all();
      pe_comp_done = '1;
      rst = 1'b1;
      #1;
      check("midrst_state", state_dbg, IDLE);
      check("midrst_busy", busy, 0);
      check("midrst_rdy", rx_if.rx_rdy, 0);
      check("midrst_layer_idx", layer_idx, 0);
      tick();
      rst = 1'b0;
      pe_comp_done = '0;
      tick(); tick(); tick();
      check("midrst_no_run_done", run_done_cnt, exp_runs);
      check("midrst_queue_empty", exp_q.size(), 0);
      exp_q.push_back(4'd0);
      do_start(4'd0);
      run_layers(1);

      // Maximum layer count: 2^LW layers without wrap.
      for (int l = 0; l < (1 << LW); l++) exp_q.push_back(LW'(l));
      do_start(4'd15);
      run_layers(1 << LW);
      check("max_layer_idx", layer_idx, 15);

      tick();
      check("final_queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/root_layer_ctrl.md
ROOT_LAYER_CTRL -- requirements
Module: root_layer_ctrl

Interface
REQ-001 SHALL have parameter NUM_PE, default 16, number of PEs on the network.
REQ-002 SHALL have parameter PE_IDX_WIDTH, default 4, width of a PE index (clog2 NUM_PE).
REQ-003 SHALL have parameter LAYER_WIDTH, default 4, width of layer count/index.
REQ-004 SHALL have parameter DATA_WIDTH, default 16, router payload width.
REQ-005 SHALL have clk  input  1  system clock; rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have start  input  1  one-cycle pulse, begin a network run (ignored unless IDLE).
REQ-007 SHALL have layer_no  input  LAYER_WIDTH  number of layers minus one, sampled on accepted start.
REQ-008 SHALL have rx_valid  input  1  packet from router present at root.
REQ-009 SHALL have rx_ctrl  input  1  router address MSB, marks a broadcast-done control packet.
REQ-010 SHALL have rx_data  input  DATA_WIDTH  payload; low PE_IDX_WIDTH bits = sender PE index.
REQ-011 SHALL have rx_rdy  output  1  root accepts packet this cycle.
REQ-012 SHALL have pe_comp_done  input  NUM_PE  per-PE level, PE finished computing current layer.
REQ-013 SHALL have pe_start_calc  output  1  one-cycle pulse to all PEs, start layer.
REQ-014 SHALL have layer_idx  output  LAYER_WIDTH  index of layer in progress.
REQ-015 SHALL have busy  output  1  run in progress; run_done  output  1  one-cycle pulse at run end.
REQ-016 SHALL have dup_err  output  1  sticky, duplicate done packet from one PE within a layer.

Function
REQ-017 SHALL implement states IDLE, START, BCAST, COMP, NEXT.
REQ-018 IDLE: on start, capture layer_no, clear layer_idx, go START next cycle.
REQ-019 START: assert pe_start_calc for exactly one cycle, clear bcast_mask, go BCAST.
REQ-020 rx_rdy SHALL be 1 in BCAST and COMP, 0 otherwise; a packet is accepted when rx_valid & rx_rdy.
REQ-021 Accepted packet with rx_ctrl=1 SHALL set bcast_mask[rx_data index]; if bit already set, set dup_err.
REQ-022 Accepted packet with rx_ctrl=0 SHALL be consumed and discarded; index >= NUM_PE SHALL be ignored.
REQ-023 BCAST→COMP when bcast_mask (including the bit set in the current cycle) is all ones.
REQ-024 COMP→NEXT when pe_comp_done is all ones (registered check, one cycle after condition).
REQ-025 NEXT: if layer_idx == captured layer_no, pulse run_done, go IDLE; else layer_idx+1, go START.
REQ-026 Latency start→pe_start_calc SHALL be 1 cycle; last done packet→COMP entry 1 cycle.
REQ-027 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-028 layer_idx SHALL not wrap within a run; layer_no = max value SHALL run 2^LAYER_WIDTH layers.
REQ-029 dup_err SHALL clear only on accepted start or reset.

Reset
REQ-030 rst SHALL force IDLE, layer_idx=0, bcast_mask=0, captured layer_no=0, dup_err=0 immediately.
REQ-031 During/after reset pe_start_calc=0, run_done=0, busy=0, rx_rdy=0.
REQ-032 Reset mid-run SHALL abandon the run with no run_done pulse; next start begins at layer 0.

Structure
REQ-033 State encodings and the control-packet address-MSB convention SHALL live in the shared router/PE header package.
REQ-034 Sub-module done_mask_tracker (set-by-index bitmap, all-ones detect, duplicate flag, clear) SHALL be used.
REQ-035 State register and next-state logic SHALL be separated; outputs pe_start_calc/run_done registered-free Moore decode.

Verification
REQ-036 start, layer_no=0, 16 distinct done packets, pe_comp_done=all ones → one pe_start_calc, run_done once, busy low after.
REQ-037 layer_no=2 → exactly 3 pe_start_calc pulses, layer_idx 0,1,2, then run_done.
REQ-038 PE 5 sends two done packets in a layer → dup_err=1, stays BCAST until remaining 15 arrive.
REQ-039 Data packets (rx_ctrl=0) and index 20 interleaved → mask unchanged, no state change.
REQ-040 rst asserted in COMP of layer 1 → IDLE, no run_done; new start restarts at layer_idx=0.
REQ-041 start pulsed while busy → ignored, layer_no change not captured.
